// File: rtl/hit_judge.sv
// hit_judge: judges drum pad edges against the latched note and drives score pulses and combo; HIT_JUDGE_EMPTY_PENALTY_EN penalises pad edges with an empty queue
module hit_judge #(
  parameter int WINDOW = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       note_valid,
  input  logic       note_type,
  output logic       note_ready,
  input  logic       btn_don,
  input  logic       btn_ka,
  output logic       increase_score,
  output logic       decrease_score,
  output logic [7:0] combo,
  output logic       busy
);
  typedef enum logic {IDLE, JUDGE} state_t;
  state_t state, state_n;
  logic note_q, note_n, don_q, ka_q, don_edge, ka_edge, hit, inc_n, dec_n;
  logic [7:0] timer, timer_n, combo_n;
  assign don_edge = btn_don & ~don_q;
  assign ka_edge = btn_ka & ~ka_q;
  assign hit = (don_edge ^ ka_edge) && (ka_edge == note_q);
  assign note_ready = state == IDLE;
  assign busy = state == JUDGE;
  always_comb begin
    state_n = state;
    note_n = note_q;
    timer_n = timer;
    inc_n = 1'b0;
    dec_n = 1'b0;
    combo_n = combo;
    if (state == IDLE) begin
      if (note_valid) begin
        state_n = JUDGE;
        note_n = note_type;
        timer_n = 8'(WINDOW);
      end
`ifdef HIT_JUDGE_EMPTY_PENALTY_EN
      else if ((don_edge | ka_edge) && !(increase_score | decrease_score)) begin
        dec_n = 1'b1;
        combo_n = 8'd0;
      end
`endif
    end else if (don_edge | ka_edge) begin
      state_n = IDLE;
      inc_n = hit;
      dec_n = !hit;
      combo_n = hit ? combo + {7'd0, combo != 8'hff} : 8'd0;
    end else if (tick) begin
      timer_n = timer - 8'd1;
      if (timer == 8'd1) begin
        state_n = IDLE;
        dec_n = 1'b1;
        combo_n = 8'd0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      note_q <= 1'b0;
      timer <= 8'd0;
      don_q <= 1'b1;
      ka_q <= 1'b1;
      increase_score <= 1'b0;
      decrease_score <= 1'b0;
      combo <= 8'd0;
    end else begin
      state <= state_n;
      note_q <= note_n;
      timer <= timer_n;
      don_q <= btn_don;
      ka_q <= btn_ka;
      increase_score <= inc_n;
      decrease_score <= dec_n;
      combo <= combo_n;
    end
  end
endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge: directed self-checking bench for hit_judge (WINDOW=4)
module tb_hit_judge;
  localparam int W = 4;
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0, note_valid = 1'b0, note_type = 1'b0;
  logic btn_don = 1'b0, btn_ka = 1'b0;
  logic note_ready, increase_score, decrease_score, busy;
  logic [7:0] combo;
  int tests = 0, fails = 0, inc_cnt = 0, viol = 0, base;
  logic prev = 1'b0;
  bit pen;
  hit_judge #(.WINDOW(W)) dut (
    .clk(clk), .reset(reset), .tick(tick), .note_valid(note_valid), .note_type(note_type),
    .note_ready(note_ready), .btn_don(btn_don), .btn_ka(btn_ka),
    .increase_score(increase_score), .decrease_score(decrease_score), .combo(combo), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (increase_score) inc_cnt++;
    if (increase_score && decrease_score) viol++;
    if ((increase_score | decrease_score) && prev) viol++;
    prev = increase_score | decrease_score;
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("no_early_pulse", {30'd0, increase_score, decrease_score}, 0);
      cyc();
    end
  endtask
  initial begin
`ifdef HIT_JUDGE_EMPTY_PENALTY_EN
    pen = 1'b1;
`else
    pen = 1'b0;
`endif
    cyc();
    cyc();
    chk("rst_ready", note_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_inc", increase_score, 0);
    chk("rst_dec", decrease_score, 0);
    chk("rst_combo", combo, 0);
    chk("rst_timer", dut.timer, 0);
    reset = 1'b0;
    cyc();
    note_valid = 1'b1; note_type = 1'b0;
    cyc();
    note_valid = 1'b0;
    chk("judge_busy", busy, 1);
    chk("judge_ready", note_ready, 0);
    tick_n(3);
    btn_don = 1'b1;
    cyc();
    chk("hit_inc", increase_score, 1);
    chk("hit_dec", decrease_score, 0);
    chk("hit_combo", combo, 1);
    chk("hit_ready", note_ready, 1);
    btn_don = 1'b0;
    cyc();
    chk("hit_inc_one", increase_score, 0);
    for (int i = 0; i < 4; i++) begin
      note_valid = 1'b1; note_type = 1'b1;
      cyc();
      note_valid = 1'b0; btn_ka = 1'b1;
      cyc();
      btn_ka = 1'b0;
      cyc();
    end
    chk("combo5", combo, 5);
    note_valid = 1'b1; note_type = 1'b1;
    cyc();
    note_valid = 1'b0;
    tick_n(W - 1);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("miss_dec", decrease_score, 1);
    chk("miss_inc", increase_score, 0);
    chk("miss_combo", combo, 0);
    chk("miss_ready", note_ready, 1);
    cyc();
    chk("miss_dec_one", decrease_score, 0);
    note_valid = 1'b1; note_type = 1'b1;
    cyc();
    note_valid = 1'b0; btn_don = 1'b1;
    cyc();
    chk("wrong_dec", decrease_score, 1);
    chk("wrong_inc", increase_score, 0);
    btn_don = 1'b0;
    cyc();
    note_valid = 1'b1; note_type = 1'b0;
    cyc();
    note_valid = 1'b0; btn_don = 1'b1; btn_ka = 1'b1;
    cyc();
    chk("both_dec", decrease_score, 1);
    chk("both_inc", increase_score, 0);
    btn_don = 1'b0; btn_ka = 1'b0;
    cyc();
    note_valid = 1'b1; note_type = 1'b0;
    cyc();
    note_valid = 1'b0;
    tick_n(W - 1);
    tick = 1'b1; btn_don = 1'b1;
    cyc();
    tick = 1'b0;
    chk("expire_inc", increase_score, 1);
    chk("expire_dec", decrease_score, 0);
    chk("expire_combo", combo, 1);
    cyc();
    chk("expire_no_miss", decrease_score, 0);
    note_valid = 1'b1; note_type = 1'b0;
    cyc();
    note_valid = 1'b0;
    tick_n(W - 1);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("held_miss", decrease_score, 1);
    chk("held_no_hit", increase_score, 0);
    btn_don = 1'b0;
    cyc();
    note_valid = 1'b1;
    cyc();
    note_valid = 1'b0; btn_don = 1'b1;
    cyc();
    btn_don = 1'b0;
    chk("pre_rst_combo", combo, 1);
    note_valid = 1'b1;
    cyc();
    note_valid = 1'b0;
    tick_n(W - 2);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rstj_ready", note_ready, 1);
    chk("rstj_pulse", {30'd0, increase_score, decrease_score}, 0);
    chk("rstj_combo", combo, 0);
    tick_n(W);
    chk("rstj_idle", busy, 0);
    base = inc_cnt;
    note_valid = 1'b1; note_type = 1'b0;
    for (int i = 0; i < 260; i++) begin
      btn_don = 1'b0;
      cyc();
      btn_don = 1'b1;
      cyc();
    end
    note_valid = 1'b0; btn_don = 1'b0;
    cyc();
    cyc();
    chk("sat_pulses", inc_cnt - base, 260);
    chk("sat_combo", combo, 255);
    btn_ka = 1'b1;
    cyc();
    chk("empty_dec", decrease_score, pen);
    btn_ka = 1'b0;
    cyc();
    chk("empty_dec_one", decrease_score, 0);
    chk("empty_combo", combo, pen ? 0 : 255);
    note_valid = 1'b1; note_type = 1'b0; btn_don = 1'b1;
    cyc();
    note_valid = 1'b0;
    chk("accept_edge_busy", busy, 1);
    cyc();
    chk("accept_edge_ignored", {30'd0, increase_score, decrease_score}, 0);
    btn_don = 1'b0;
    cyc();
    btn_don = 1'b1;
    cyc();
    chk("accept_then_hit", increase_score, 1);
    chk("accept_combo", combo, pen ? 1 : 255);
    btn_don = 1'b0;
    cyc();
    chk("pulse_rules", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
